uart_rx_fifo: RTL

- Receive-side byte buffer sitting directly downstream of the UART receiver.
- Captures each received byte, qualified by the receiver's one-cycle done pulse, into a circular FIFO.
- Presents bytes to the bus-side register interface through a first-word-fall-through valid/ready port.
- Tracks fill level, flags overrun (byte lost when full) and raises a level/overrun interrupt.

---
 rtl/uart_rx_fifo_pkg.sv | 14 +
 rtl/uart_fifo_mem.sv | 25 ++
 rtl/uart_rx_fifo.sv | 94 +++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants and the RX FIFO sizing helper.
// Used by the receiver, the transmitter and both FIFOs.
package uart_rx_fifo_pkg;

    localparam int UART_DATA_W           = 8;
    localparam int RX_FIFO_DEPTH         = 16;
    localparam int RX_FIFO_IRQ_THRESHOLD = 1;

    // A level counter has to reach DEPTH itself, so it needs one bit more than a pointer.
    function automatic int fifo_level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array FIFO storage: synchronous write port, asynchronous read port.
// Shared by the RX and TX FIFOs.
module uart_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO: captures bytes from the UART receiver and presents them first-word-fall-through.
// Tracks fill level and a sticky overrun flag; irq is level-sensitive.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_W        = UART_DATA_W,
    parameter int DEPTH         = RX_FIFO_DEPTH,
    parameter int IRQ_THRESHOLD = RX_FIFO_IRQ_THRESHOLD
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_W-1:0]              rx_data,
    input  logic                           rx_done,
    output logic [DATA_W-1:0]              rd_data,
    output logic                           rd_valid,
    input  logic                           rd_ready,
    input  logic                           flush,
    input  logic                           overrun_clr,
    output logic [fifo_level_w(DEPTH)-1:0] level,
    output logic                           empty,
    output logic                           full,
    output logic                           overrun,
    output logic                           irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = fifo_level_w(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          push;
    logic          drop;

    // Flush suppresses both ports; a pop frees a slot, so a full FIFO may still accept a push.
    always_comb begin
        pop  = rd_valid && rd_ready && !flush;
        push = rx_done && (!full || pop) && !flush;
        drop = rx_done && full && !pop && !flush;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    // Setting the flag wins over a clear in the same cycle, so a drop is never hidden.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    assign empty    = (level == '0);
    assign full     = (level == LW'(DEPTH));
    assign rd_valid = !empty;
    assign irq      = (level >= LW'(IRQ_THRESHOLD)) || overrun;

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (rx_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule
